// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types for the CPU-to-AXI bridge.
// Contents: FSM state encoding, AXI channel widths and the latched request payload.
package cpu_axi_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    // Request captured at accept time; drives the AXI address/data payloads.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        src_e              src;
    } req_t;

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU instruction and data request ports onto one AXI master.
// At most one transaction is outstanding; the data port wins arbitration.
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    state_e            state;
    state_e            state_nxt;
    req_t              req_q;
    logic              aw_done;
    logic              w_done;
    logic [DATA_W-1:0] inst_rdata_q;
    logic [DATA_W-1:0] data_rdata_q;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (data_req) begin
                    state_nxt = (|data_wstrb) ? ST_WR_REQ : ST_RD_ADDR;
                end else if (inst_req) begin
                    state_nxt = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: if (arready) state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (rvalid)  state_nxt = ST_DONE;
            ST_WR_REQ: begin
                // AW and W may complete in either order or together.
                if ((aw_done || awready) && (w_done || wready)) begin
                    state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: if (bvalid) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; addr_ok is combinational so a request is accepted in its first idle cycle.
    always_comb begin
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (state)
            ST_IDLE: begin
                data_addr_ok = data_req;
                inst_addr_ok = inst_req && !data_req;
            end
            ST_RD_ADDR: arvalid = 1'b1;
            ST_RD_DATA: rready  = 1'b1;
            ST_WR_REQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
            end
            ST_WR_RESP: bready = 1'b1;
            ST_DONE: begin
                inst_data_ok = (req_q.src == SRC_INST);
                data_data_ok = (req_q.src == SRC_DATA);
            end
            default: ;
        endcase
    end

    // Request latch, write-handshake tracking and read-data capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q        <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if (data_addr_ok) begin
                req_q   <= '{addr: data_addr, wdata: data_wdata, wstrb: data_wstrb, src: SRC_DATA};
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (inst_addr_ok) begin
                req_q   <= '{addr: inst_addr, wdata: DATA_W'(0), wstrb: STRB_W'(0), src: SRC_INST};
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
            if (rready && rvalid) begin
                if (req_q.src == SRC_INST) begin
                    inst_rdata_q <= rdata;
                end else begin
                    data_rdata_q <= rdata;
                end
            end
        end
    end

    assign araddr     = req_q.addr;
    assign awaddr     = req_q.addr;
    assign wdata      = req_q.wdata;
    assign wstrb      = req_q.wstrb;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge with a wait-state-programmable AXI slave.
// Cycle 0 is the cycle a request is presented; checks sample mid-cycle after the negedge.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready, bvalid, bready;

    int n_cmp = 0;
    int n_err = 0;

    // Slave wait-state knobs and counters
    int ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 1;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    logic [31:0] slv_rdata = 32'h0;

    cpu_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Slave responds at the negedge to valids decoded from the DUT state.
    always @(negedge clk) begin
        if (arvalid) begin
            arready = (ar_cnt >= ar_wait);
            ar_cnt  = arready ? 0 : ar_cnt + 1;
        end else arready = 1'b0;
        if (awvalid) begin
            awready = (aw_cnt >= aw_wait);
            aw_cnt  = awready ? 0 : aw_cnt + 1;
        end else awready = 1'b0;
        if (wvalid) begin
            wready = (w_cnt >= w_wait);
            w_cnt  = wready ? 0 : w_cnt + 1;
        end else wready = 1'b0;
        if (rready) begin
            rvalid = (r_cnt >= r_wait);
            r_cnt  = rvalid ? 0 : r_cnt + 1;
        end else rvalid = 1'b0;
        rdata = rvalid ? slv_rdata : 32'h0;
        if (bready) begin
            bvalid = (b_cnt >= b_wait);
            b_cnt  = bvalid ? 0 : b_cnt + 1;
        end else bvalid = 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " valids"}, {28'h0, arvalid, awvalid, wvalid, 1'b0}, 32'h0);
        check_eq({tag, " readys"}, {30'h0, rready, bready}, 32'h0);
        check_eq({tag, " oks"}, {28'h0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0; rdata = '0;

        // Reset state
        cyc(); cyc();
        check_idle_outputs("reset");
        check_eq("reset araddr", araddr, 32'h0);
        check_eq("reset wdata", wdata, 32'h0);
        check_eq("reset inst_rdata", inst_rdata, 32'h0);
        check_eq("reset data_rdata", data_rdata, 32'h0);
        resetn = 1'b1;
        cyc();

        // Zero-wait fetch
        slv_rdata = 32'h0280_0404;
        inst_req = 1'b1; inst_addr = 32'h1C00_0000;
        #1 check_eq("fetch c0 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
        check_eq("fetch c0 data_addr_ok", {31'h0, data_addr_ok}, 32'h0);
        cyc(); inst_req = 1'b0;
        check_eq("fetch c1 arvalid", {31'h0, arvalid}, 32'h1);
        check_eq("fetch c1 araddr", araddr, 32'h1C00_0000);
        cyc();
        check_eq("fetch c2 rready", {31'h0, rready}, 32'h1);
        check_eq("fetch c2 inst_data_ok", {31'h0, inst_data_ok}, 32'h0);
        cyc();
        check_eq("fetch c3 inst_data_ok", {31'h0, inst_data_ok}, 32'h1);
        check_eq("fetch c3 inst_rdata", inst_rdata, 32'h0280_0404);
        check_eq("fetch c3 data_data_ok", {31'h0, data_data_ok}, 32'h0);
        cyc();
        check_eq("fetch c4 inst_data_ok", {31'h0, inst_data_ok}, 32'h0);
        check_eq("fetch c4 inst_rdata hold", inst_rdata, 32'h0280_0404);

        // Simultaneous requests: data load first, then the held fetch
        slv_rdata = 32'h1122_3344;
        inst_req = 1'b1; inst_addr = 32'h1C00_0004;
        data_req = 1'b1; data_addr = 32'h0000_0080; data_wstrb = 4'h0;
        #1 check_eq("arb c0 data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
        check_eq("arb c0 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
        cyc(); data_req = 1'b0;
        check_eq("arb c1 araddr", araddr, 32'h0000_0080);
        check_eq("arb c1 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
        cyc();
        check_eq("arb c2 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
        cyc();
        check_eq("arb c3 data_data_ok", {31'h0, data_data_ok}, 32'h1);
        check_eq("arb c3 data_rdata", data_rdata, 32'h1122_3344);
        check_eq("arb c3 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
        check_eq("arb c3 inst_rdata hold", inst_rdata, 32'h0280_0404);
        cyc();
        slv_rdata = 32'hCAFE_F00D;
        check_eq("arb c4 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
        cyc(); inst_req = 1'b0;
        check_eq("arb c5 araddr", araddr, 32'h1C00_0004);
        cyc(); cyc();
        check_eq("arb c7 inst_data_ok", {31'h0, inst_data_ok}, 32'h1);
        check_eq("arb c7 inst_rdata", inst_rdata, 32'hCAFE_F00D);
        check_eq("arb c7 data_rdata hold", data_rdata, 32'h1122_3344);
        cyc();

        // Store with staggered AW/W handshakes
        w_wait = 2;
        data_req = 1'b1; data_addr = 32'h0000_0100; data_wstrb = 4'h3; data_wdata = 32'hDEAD_BEEF;
        #1 check_eq("st c0 data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
        cyc(); data_req = 1'b0; data_wstrb = 4'h0; data_wdata = 32'h0;
        check_eq("st c1 aw/w valid", {30'h0, awvalid, wvalid}, 32'h3);
        check_eq("st c1 awaddr", awaddr, 32'h0000_0100);
        check_eq("st c1 wdata", wdata, 32'hDEAD_BEEF);
        check_eq("st c1 wstrb", {28'h0, wstrb}, 32'h3);
        cyc();
        check_eq("st c2 aw/w valid", {30'h0, awvalid, wvalid}, 32'h1);
        check_eq("st c2 wdata stable", wdata, 32'hDEAD_BEEF);
        cyc();
        check_eq("st c3 aw/w valid", {30'h0, awvalid, wvalid}, 32'h1);
        check_eq("st c3 wready", {31'h0, wready}, 32'h1);
        cyc();
        check_eq("st c4 aw/w valid", {30'h0, awvalid, wvalid}, 32'h0);
        check_eq("st c4 bready", {31'h0, bready}, 32'h1);
        cyc();
        check_eq("st c5 data_data_ok", {31'h0, data_data_ok}, 32'h0);
        cyc();
        check_eq("st c6 data_data_ok", {31'h0, data_data_ok}, 32'h1);
        check_eq("st c6 data_rdata hold", data_rdata, 32'h1122_3344);
        cyc();
        check_eq("st c7 data_data_ok", {31'h0, data_data_ok}, 32'h0);
        w_wait = 0;

        // Zero-wait store: data_ok on cycle 4
        data_req = 1'b1; data_addr = 32'h0000_0104; data_wstrb = 4'hF; data_wdata = 32'h0123_4567;
        cyc(); data_req = 1'b0;
        check_eq("zst c1 wstrb", {28'h0, wstrb}, 32'hF);
        cyc(); cyc();
        check_eq("zst c3 data_data_ok", {31'h0, data_data_ok}, 32'h0);
        cyc();
        check_eq("zst c4 data_data_ok", {31'h0, data_data_ok}, 32'h1);
        cyc();

        // arready held low for five cycles
        ar_wait = 5;
        slv_rdata = 32'h5555_AAAA;
        data_req = 1'b1; data_addr = 32'h0000_0200; data_wstrb = 4'h0;
        cyc(); data_req = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1C00_0008;
        for (int i = 1; i <= 5; i++) begin
            check_eq($sformatf("arw c%0d arvalid", i), {31'h0, arvalid}, 32'h1);
            check_eq($sformatf("arw c%0d araddr", i), araddr, 32'h0000_0200);
            check_eq($sformatf("arw c%0d arready", i), {31'h0, arready}, 32'h0);
            check_eq($sformatf("arw c%0d addr_ok", i), {30'h0, inst_addr_ok, data_addr_ok}, 32'h0);
            cyc();
        end
        inst_req = 1'b0;
        check_eq("arw c6 arvalid", {31'h0, arvalid}, 32'h1);
        check_eq("arw c6 arready", {31'h0, arready}, 32'h1);
        cyc();
        check_eq("arw c7 arvalid", {31'h0, arvalid}, 32'h0);
        cyc();
        check_eq("arw c8 data_data_ok", {31'h0, data_data_ok}, 32'h1);
        check_eq("arw c8 data_rdata", data_rdata, 32'h5555_AAAA);
        ar_wait = 0;
        cyc();

        // Reset while waiting in RD_DATA
        r_wait = 10;
        data_req = 1'b1; data_addr = 32'h0000_0300; data_wstrb = 4'h0;
        cyc(); data_req = 1'b0;
        cyc();
        check_eq("rst c2 rready", {31'h0, rready}, 32'h1);
        resetn = 1'b0;
        #1 check_idle_outputs("rst async");
        check_eq("rst araddr", araddr, 32'h0);
        check_eq("rst inst_rdata", inst_rdata, 32'h0);
        check_eq("rst data_rdata", data_rdata, 32'h0);
        r_wait = 0; r_cnt = 0;
        cyc(); cyc();
        check_eq("rst hold data_data_ok", {31'h0, data_data_ok}, 32'h0);
        resetn = 1'b1;
        cyc();
        check_idle_outputs("rst release");
        cyc();
        check_eq("rst post data_data_ok", {31'h0, data_data_ok}, 32'h0);

        // Normal fetch after reset
        slv_rdata = 32'h0BAD_F00D;
        inst_req = 1'b1; inst_addr = 32'h1C00_0010;
        #1 check_eq("post c0 inst_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
        cyc(); inst_req = 1'b0;
        check_eq("post c1 araddr", araddr, 32'h1C00_0010);
        cyc(); cyc();
        check_eq("post c3 inst_data_ok", {31'h0, inst_data_ok}, 32'h1);
        check_eq("post c3 inst_rdata", inst_rdata, 32'h0BAD_F00D);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
